// File: rtl/dram_port_arbiter.sv
// Two-port arbiter for the single-ported data RAM: port 0 (CPU) has priority, port 1 is aged.
// Optional ARB_LOCK_EN lets port 1 hold the RAM across a locked burst.
module dram_port_arbiter #(
  parameter int unsigned AW       = 14,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_wmask,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_wmask,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  input  logic          m1_lock,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_wmask,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  // Encoded as {valid, port}.
  typedef enum logic [1:0] {
    TagNone = 2'b00,
    TagP0   = 2'b10,
    TagP1   = 2'b11
  } rd_tag_e;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  rd_tag_e    rd_tag_q, rd_tag_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       forced;

`ifdef ARB_LOCK_EN
  logic lock_q, lock_d;
`else
  logic unused_lock;
  assign unused_lock = m1_lock;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:AW+2], m0_addr[1:0], m1_addr[31:AW+2], m1_addr[1:0]};

  assign forced = m1_req && (wait_cnt_q == MaxWait);

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (resetn) begin
`ifdef ARB_LOCK_EN
      if (lock_q) begin
        m1_gnt = m1_req;
      end else
`endif
      if (forced) begin
        m1_gnt = 1'b1;
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!m1_req || m1_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MaxWait) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
`ifdef ARB_LOCK_EN
    if (lock_q) begin
      wait_cnt_d = 4'd0;
    end
    lock_d = lock_q;
    if (m1_gnt) begin
      lock_d = m1_lock;
    end
`endif
  end

  // Idle cycles still present port 0's address so the RAM sees a stable index.
  always_comb begin
    ram_addr  = m0_addr[AW+1:2];
    ram_wdata = m0_wdata;
    ram_wmask = 4'b0000;
    rd_tag_d  = TagNone;
    if (m1_gnt) begin
      ram_addr  = m1_addr[AW+1:2];
      ram_wdata = m1_wdata;
      ram_wmask = m1_we ? m1_wmask : 4'b0000;
      rd_tag_d  = m1_we ? TagNone : TagP1;
    end else if (m0_gnt) begin
      ram_wmask = m0_we ? m0_wmask : 4'b0000;
      rd_tag_d  = m0_we ? TagNone : TagP0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_tag_q   <= TagNone;
      wait_cnt_q <= 4'd0;
`ifdef ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      rd_tag_q   <= rd_tag_d;
      wait_cnt_q <= wait_cnt_d;
`ifdef ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign m0_rvalid = resetn && (rd_tag_q == TagP0);
  assign m1_rvalid = resetn && (rd_tag_q == TagP1);
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter with a behavioural read-first RAM.
module tb_dram_port_arbiter;
  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          resetn;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [3:0]    m0_wmask, m1_wmask;
  logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_wmask;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          preload;

  logic [31:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dram_port_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wmask(m0_wmask), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wmask(m1_wmask), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_lock(m1_lock),
    .ram_addr(ram_addr), .ram_wmask(ram_wmask), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (preload) begin
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'h11223344;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ram_wmask[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_wmask = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_wmask = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
  endtask

  initial begin
    resetn = 0; preload = 1;
    idle();
    next_cycle(); next_cycle();
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_wmask", ram_wmask, 0);
    chk("rst_wait_cnt", dut.wait_cnt_q, 0);
    next_cycle();
    resetn = 1; preload = 0;

    // Lone m0 read of word 4.
    m0_req = 1; m0_addr = 32'h10;
    #1;
    chk("t1_m0_gnt", m0_gnt, 1);
    chk("t1_m1_gnt", m1_gnt, 0);
    chk("t1_ram_addr", ram_addr, 4);
    chk("t1_ram_wmask", ram_wmask, 0);
    next_cycle();
    idle();
    #1;
    chk("t1_m0_rvalid", m0_rvalid, 1);
    chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    chk("t1_idle_gnt", m0_gnt, 0);

    // Both requesting continuously: m1 forced every fifth cycle.
    next_cycle();
    m0_req = 1; m0_addr = 32'h10;
    m1_req = 1; m1_addr = 32'h20;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("t2_m0_gnt_c%0d", k), m0_gnt, (k % 5 == 4) ? 0 : 1);
      chk($sformatf("t2_m1_gnt_c%0d", k), m1_gnt, (k % 5 == 4) ? 1 : 0);
      if (k == 4) chk("t2_forced_addr", ram_addr, 8);
      next_cycle();
    end
    idle();
    #1;
    chk("t2_last_m1_rvalid", m1_rvalid, 1);
    chk("t2_last_m1_rdata", m1_rdata, 32'h11223344);
    chk("t2_last_m0_rvalid", m0_rvalid, 0);

    // m1 byte-lane write then read-back of the same word.
    next_cycle();
    m1_req = 1; m1_we = 1; m1_wmask = 4'b0100; m1_addr = 32'h22; m1_wdata = 32'h00AB0000;
    #1;
    chk("t3_wr_gnt", m1_gnt, 1);
    chk("t3_wr_wmask", ram_wmask, 4'b0100);
    chk("t3_wr_addr", ram_addr, 8);
    chk("t3_wr_wdata", ram_wdata, 32'h00AB0000);
    next_cycle();
    m1_we = 0; m1_wmask = 0; m1_wdata = 0;
    #1;
    chk("t3_wr_no_rvalid", m1_rvalid, 0);
    chk("t3_rd_gnt", m1_gnt, 1);
    chk("t3_rd_wmask", ram_wmask, 0);
    next_cycle();
    idle();
    #1;
    chk("t3_rd_rvalid", m1_rvalid, 1);
    chk("t3_rd_rdata", m1_rdata, 32'h11AB3344);
    chk("t3_rd_byte2", {24'h0, m1_rdata[23:16]}, 32'hAB);

    // m0 write with an empty mask is a granted no-op.
    next_cycle();
    m0_req = 1; m0_we = 1; m0_wmask = 0; m0_addr = 32'h10; m0_wdata = 32'hFFFFFFFF;
    #1;
    chk("t5_gnt", m0_gnt, 1);
    chk("t5_wmask", ram_wmask, 0);
    next_cycle();
    m0_we = 0; m0_wdata = 0;
    #1;
    chk("t5_no_rvalid", m0_rvalid, 0);
    next_cycle();
    idle();
    #1;
    chk("t5_rd_rvalid", m0_rvalid, 1);
    chk("t5_unchanged", m0_rdata, 32'hDEADBEEF);

    // Reset dropped while a granted read is in flight.
    next_cycle();
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20;
    #1;
    chk("t4_pre_gnt", m0_gnt, 1);
    next_cycle();
    resetn = 0;
    #1;
    chk("t4_pre_wait_cnt", dut.wait_cnt_q, 1);
    chk("t4_rst_m0_gnt", m0_gnt, 0);
    chk("t4_rst_m1_gnt", m1_gnt, 0);
    chk("t4_rst_wmask", ram_wmask, 0);
    chk("t4_rst_m0_rvalid", m0_rvalid, 0);
    next_cycle();
    resetn = 1;
    idle();
    #1;
    chk("t4_post_m0_rvalid", m0_rvalid, 0);
    chk("t4_post_wait_cnt", dut.wait_cnt_q, 0);

    // m1 locked burst of 3 reads (lock=1,1,0) against a held m0 request.
    next_cycle();
    m0_req = 1; m0_addr = 32'h10;
    m1_req = 1; m1_addr = 32'h20; m1_lock = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t6_m0_first_c%0d", k), m0_gnt, 1);
      next_cycle();
    end
    #1;
    chk("t6_beat1_m1_gnt", m1_gnt, 1);
    chk("t6_beat1_m0_gnt", m0_gnt, 0);
    next_cycle();
`ifdef ARB_LOCK_EN
    m1_addr = 32'h24;
    #1;
    chk("t6_beat2_m1_gnt", m1_gnt, 1);
    chk("t6_beat2_m0_gnt", m0_gnt, 0);
    next_cycle();
    m1_addr = 32'h28; m1_lock = 0;
    #1;
    chk("t6_beat3_m1_gnt", m1_gnt, 1);
    chk("t6_beat3_m0_gnt", m0_gnt, 0);
    next_cycle();
    m1_req = 0;
    #1;
    chk("t6_after_m0_gnt", m0_gnt, 1);
    chk("t6_after_m1_rvalid", m1_rvalid, 1);
`else
    #1;
    chk("t6_nolock_m0_gnt", m0_gnt, 1);
    chk("t6_nolock_m1_gnt", m1_gnt, 0);
`endif
    next_cycle();
    idle();
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
